irq_sequencer: RTL and testbench
================================

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 Parameter: ACK_TIMEOUT, 255, cycles in ASSERT without a valid ack before the request is withdrawn; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SRC_EVT  input  8  per-source event; a 1 sampled on any edge sets that source's pending bit.
REQ-005 MASK  input  8  per-source mask; 1 = not eligible for selection, pending still latches.
REQ-006 ACK  input  1  core acknowledge strobe.
REQ-007 ACKNUM  input  3  index being acknowledged; qualifies ACK.
REQ-008 IRQ  output  8  registered request lines, always one-hot or all-zero.
REQ-009 PENDING  output  8  registered pending bits.
REQ-010 BUSY  output  1  1 while state is ASSERT or GAP.
REQ-011 TIMEOUT  output  1  one-cycle pulse when a request is withdrawn on timeout.

Function
REQ-012 States SHALL be IDLE, ASSERT and GAP, held in a registered state variable.
REQ-013 PENDING[i] SHALL set on any edge where SRC_EVT[i]=1, and SHALL clear only on a valid ack of i.
REQ-014 Set SHALL win over clear: SRC_EVT[i]=1 on the ack edge of i leaves PENDING[i]=1.
REQ-015 IDLE: if (PENDING & ~MASK) != 0, the selected index SHALL be latched as CUR, IRQ SHALL become onehot(CUR) at the same edge, and state SHALL go to ASSERT.
REQ-016 Latency: SRC_EVT[i] high at edge k gives PENDING[i]=1 after edge k and IRQ[i]=1 after edge k+1, when idle and unmasked.
REQ-017 ASSERT: ACK=1 with ACKNUM=CUR SHALL clear PENDING[CUR] and IRQ, then go to GAP.
REQ-018 ACK with ACKNUM!=CUR, or ACK in IDLE/GAP, SHALL be ignored with no state change.
REQ-019 ASSERT: MASK[CUR]=1 SHALL clear IRQ and go to GAP with PENDING[CUR] retained.
REQ-020 ASSERT: the timeout counter SHALL reset on ASSERT entry and increment each ASSERT cycle.
REQ-021 On reaching ACK_TIMEOUT (when nonzero): IRQ SHALL clear, TIMEOUT SHALL pulse for one cycle, PENDING[CUR] SHALL be retained, and state SHALL go to GAP.
REQ-022 Priority within one ASSERT edge SHALL be valid ack > mask drop > timeout.
REQ-023 GAP SHALL last exactly one cycle with IRQ=0, then go to IDLE, so a downstream decoder always sees INT low between requests.
REQ-024 IRQ SHALL never have more than one bit set in any cycle.
REQ-025 The timeout counter width SHALL be clog2(ACK_TIMEOUT+1); it SHALL saturate and SHALL never wrap.

Reset
REQ-026 While rst_n=0, independent of clk: state=IDLE, IRQ=0, PENDING=0, BUSY=0, TIMEOUT=0, CUR=0, timeout counter=0, round-robin pointer=0.
REQ-027 Reset asserted mid-ASSERT SHALL drop IRQ immediately and discard all pending bits.
REQ-028 The first edge after rst_n rises SHALL latch SRC_EVT normally.

Configuration
REQ-029 Macro IRQ_SEQ_ROUND_ROBIN_EN defined: selection SHALL search upward from pointer P, wrapping 7->0, and P SHALL become CUR+1 mod 8 on leaving ASSERT for any reason.
REQ-030 Macro IRQ_SEQ_ROUND_ROBIN_EN undefined: selection SHALL be fixed priority with the lowest eligible index first, and no pointer register SHALL exist.

Verification
REQ-031 SRC_EVT=0x04 for 1 cycle, idle, MASK=0 -> PENDING=0x04 at k+1, IRQ=0x04 at k+2; ACK with ACKNUM=2 -> IRQ=0 and PENDING=0 next edge, one GAP cycle, BUSY=0 after.
REQ-032 SRC_EVT=0x81 at once, round-robin build -> IRQ=0x01, ack, gap, IRQ=0x80; fixed build with a new 0x01 event during gap -> IRQ=0x01 again.
REQ-033 ACK_TIMEOUT=4, IRQ=0x10, no ack -> IRQ=0 after 4 ASSERT cycles, TIMEOUT pulse, PENDING[4]=1, IRQ reasserts after GAP+IDLE.
REQ-034 IRQ=0x02, ACK with ACKNUM=3 -> no change; then MASK=0x02 -> IRQ=0, PENDING[1]=1; unmask -> IRQ=0x02 reasserts.
REQ-035 ACK for CUR=5 and SRC_EVT=0x20 on the same edge -> PENDING[5] stays 1, IRQ=0x20 after GAP.
REQ-036 rst_n low mid-ASSERT -> IRQ=0 and PENDING=0 asynchronously; IRQ stays one-hot or zero throughout all tests.

Source files
------------

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches eight source events, presents one request at a time, handles ack/mask/timeout.
// Build option IRQ_SEQ_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module irq_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] SRC_EVT,
    input  logic [7:0] MASK,
    input  logic       ACK,
    input  logic [2:0] ACKNUM,
    output logic [7:0] IRQ,
    output logic [7:0] PENDING,
    output logic       BUSY,
    output logic       TIMEOUT
);
    localparam int unsigned NSRC = 8;
    localparam int unsigned IDXW = 3;
    localparam int unsigned CNTW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   cur, cur_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [NSRC-1:0]   irq_nxt, pend_nxt, clr, elig;
    logic              busy_nxt, timeout_nxt;
    logic              sel_vld, ack_hit, to_hit;
    logic [IDXW-1:0]   sel_idx;
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
    logic [IDXW-1:0]   ptr, ptr_nxt;
`endif

    assign elig    = PENDING & ~MASK;
    assign sel_vld = |elig;
    assign ack_hit = ACK && (ACKNUM == cur);
    assign cnt_inc = (cnt == {CNTW{1'b1}}) ? cnt : cnt + CNTW'(1);
    assign to_hit  = (ACK_TIMEOUT != 0) && (cnt_inc == CNTW'(ACK_TIMEOUT));

`ifdef IRQ_SEQ_ROUND_ROBIN_EN
    // Search upward from ptr with wrap; the last hit in a descending scan is the nearest one.
    always_comb begin
        sel_idx = '0;
        for (int j = int'(NSRC) - 1; j >= 0; j--) begin
            if (elig[ptr + IDXW'(j)]) sel_idx = ptr + IDXW'(j);
        end
    end
`else
    // Lowest eligible index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (elig[i]) sel_idx = IDXW'(i);
        end
    end
`endif

    // Next-state and registered-output values.
    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur;
        cnt_nxt     = cnt;
        irq_nxt     = IRQ;
        timeout_nxt = 1'b0;
        clr         = '0;
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
        ptr_nxt     = ptr;
`endif
        unique case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    cur_nxt          = sel_idx;
                    irq_nxt          = '0;
                    irq_nxt[sel_idx] = 1'b1;
                    cnt_nxt          = '0;
                    state_nxt        = S_ASSERT;
                end
            end
            S_ASSERT: begin
                cnt_nxt = cnt_inc;
                if (ack_hit) begin
                    clr[cur]  = 1'b1;
                    irq_nxt   = '0;
                    state_nxt = S_GAP;
                end else if (MASK[cur]) begin
                    irq_nxt   = '0;
                    state_nxt = S_GAP;
                end else if (to_hit) begin
                    irq_nxt     = '0;
                    timeout_nxt = 1'b1;
                    state_nxt   = S_GAP;
                end
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
                if (state_nxt == S_GAP) ptr_nxt = cur + IDXW'(1);
`endif
            end
            S_GAP: begin
                irq_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                irq_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
        // New events take precedence over an ack clear of the same source.
        pend_nxt = (PENDING & ~clr) | SRC_EVT;
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cur     <= '0;
            cnt     <= '0;
            IRQ     <= '0;
            PENDING <= '0;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b0;
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            cnt     <= cnt_nxt;
            IRQ     <= irq_nxt;
            PENDING <= pend_nxt;
            BUSY    <= busy_nxt;
            TIMEOUT <= timeout_nxt;
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
            ptr     <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_sequencer;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] SRC_EVT, MASK;
    logic       ACK;
    logic [2:0] ACKNUM;
    logic [7:0] IRQ, PENDING;
    logic       BUSY, TIMEOUT;

    int errors = 0;
    int checks = 0;

    irq_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .SRC_EVT(SRC_EVT), .MASK(MASK), .ACK(ACK), .ACKNUM(ACKNUM),
        .IRQ(IRQ), .PENDING(PENDING), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = gap; age counts cycles the request has been visible.
    logic [7:0] m_irq, m_pend;
    logic       m_busy, m_tmo;
    int         m_phase, m_cur, m_age, m_ptr, m_pick, m_start, m_idx;
    logic [7:0] m_elig;
    bit         m_acked;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_irq = 0; m_pend = 0; m_busy = 0; m_tmo = 0;
            m_phase = 0; m_cur = 0; m_age = 0; m_ptr = 0;
        end else begin
            m_acked = (m_phase == 1) && ACK && (int'(ACKNUM) == m_cur);
            m_elig  = m_pend & ~MASK;
            if (m_acked) m_pend[m_cur] = 1'b0;
            m_pend = m_pend | SRC_EVT;
            m_tmo  = 1'b0;
            if (m_phase == 0) begin
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
                m_start = m_ptr;
`else
                m_start = 0;
`endif
                m_pick = -1;
                for (int j = 0; j < 8; j++) begin
                    m_idx = (m_start + j) % 8;
                    if (m_pick < 0 && m_elig[m_idx]) m_pick = m_idx;
                end
                if (m_pick >= 0) begin
                    m_cur = m_pick; m_irq = 8'(1 << m_pick); m_age = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_acked || MASK[m_cur] || m_age == TO) begin
                    m_tmo   = !m_acked && !MASK[m_cur];
                    m_irq   = 0;
                    m_phase = 2;
                    m_ptr   = (m_cur + 1) % 8;
                end else begin
                    m_age++;
                end
            end else begin
                m_phase = 0;
            end
            m_busy = (m_phase != 0);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("irq_onehot", 8'($countones(IRQ) <= 1), 8'd1);
        if (rst_n) begin
            check("irq", IRQ, m_irq);
            check("pending", PENDING, m_pend);
            check("busy", 8'(BUSY), 8'(m_busy));
            check("timeout", 8'(TIMEOUT), 8'(m_tmo));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_irq", IRQ, 8'h00);
        check("rst_pend", PENDING, 8'h00);
        check("rst_busy", 8'(BUSY), 8'h00);
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; SRC_EVT = 0; MASK = 0; ACK = 0; ACKNUM = 0;
        cyc();
        do_reset();

        // Single source: latency, ack, gap.
        SRC_EVT = 8'h04; cyc(); SRC_EVT = 0;
        check("r031_pend_k1", PENDING, 8'h04);
        check("r031_irq_k1", IRQ, 8'h00);
        cyc();
        check("r031_irq_k2", IRQ, 8'h04);
        check("r031_busy", 8'(BUSY), 8'h01);
        ACK = 1; ACKNUM = 3'd2; cyc(); ACK = 0;
        check("r031_irq_ack", IRQ, 8'h00);
        check("r031_pend_ack", PENDING, 8'h00);
        check("r031_busy_gap", 8'(BUSY), 8'h01);
        cyc();
        check("r031_busy_idle", 8'(BUSY), 8'h00);

        // Two simultaneous sources, new event on source 0 during the gap.
        do_reset();
        SRC_EVT = 8'h81; cyc(); SRC_EVT = 0; cyc();
        check("r032_first", IRQ, 8'h01);
        ACK = 1; ACKNUM = 3'd0; cyc(); ACK = 0;
        SRC_EVT = 8'h01; cyc(); SRC_EVT = 0;
        check("r032_pend", PENDING, 8'h81);
        cyc();
`ifdef IRQ_SEQ_ROUND_ROBIN_EN
        check("r032_second", IRQ, 8'h80);
`else
        check("r032_second", IRQ, 8'h01);
`endif

        // Ack timeout after four visible cycles.
        do_reset();
        SRC_EVT = 8'h10; cyc(); SRC_EVT = 0; cyc();
        check("r033_entry", IRQ, 8'h10);
        cyc(); cyc(); cyc();
        check("r033_hold", IRQ, 8'h10);
        check("r033_no_tmo", 8'(TIMEOUT), 8'h00);
        cyc();
        check("r033_irq_drop", IRQ, 8'h00);
        check("r033_tmo", 8'(TIMEOUT), 8'h01);
        check("r033_pend", PENDING, 8'h10);
        cyc();
        check("r033_tmo_off", 8'(TIMEOUT), 8'h00);
        cyc();
        check("r033_reassert", IRQ, 8'h10);

        // Wrong ack ignored, mask drop, unmask.
        do_reset();
        SRC_EVT = 8'h02; cyc(); SRC_EVT = 0; cyc();
        ACK = 1; ACKNUM = 3'd3; cyc(); ACK = 0;
        check("r034_wrong_ack", IRQ, 8'h02);
        MASK = 8'h02; cyc();
        check("r034_mask_irq", IRQ, 8'h00);
        check("r034_mask_pend", PENDING, 8'h02);
        cyc(); MASK = 0; cyc();
        check("r034_unmask", IRQ, 8'h02);

        // Event on the same edge as its ack keeps it pending.
        do_reset();
        SRC_EVT = 8'h20; cyc(); SRC_EVT = 0; cyc();
        check("r035_irq", IRQ, 8'h20);
        ACK = 1; ACKNUM = 3'd5; SRC_EVT = 8'h20; cyc(); ACK = 0; SRC_EVT = 0;
        check("r035_pend", PENDING, 8'h20);
        check("r035_irq_gap", IRQ, 8'h00);
        cyc(); cyc();
        check("r035_reassert", IRQ, 8'h20);

        // Asynchronous reset mid-request.
        do_reset();
        SRC_EVT = 8'h08; cyc(); SRC_EVT = 0; cyc();
        check("r036_irq", IRQ, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("r036_async_irq", IRQ, 8'h00);
        check("r036_async_pend", PENDING, 8'h00);
        check("r036_async_busy", 8'(BUSY), 8'h00);
        cyc();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(0, 5))
                0: SRC_EVT = 8'(1 << $urandom_range(0, 7));
                1: SRC_EVT = 8'($urandom & $urandom & $urandom);
                default: SRC_EVT = 8'h00;
            endcase
            if ($urandom_range(0, 24) == 0)
                MASK = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
            ACK = ($urandom_range(0, 2) == 0);
            ACKNUM = ($urandom_range(0, 3) != 0) ? 3'(m_cur) : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            cyc();
        end

        SRC_EVT = 0; ACK = 0; MASK = 0;
        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
